muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit; successor to the single-cycle ALU MUL path.
- Adds high-half multiply, signed/unsigned divide and remainder.
- Sits beside the ALU in EX; the pipeline stalls on busy_o and resumes on valid_o.
- Result uses shift-add / restoring division, one bit per cycle.

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Signed operands are reduced to magnitudes up front; the result sign is restored in FIX.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             kill_i,
   input  logic [1:0]       op_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic                 neg_q, neg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [WIDTH-1:0]     data_q, data_d;

   logic                 s1, s2, div_zero, div_ovf;
   logic [WIDTH-1:0]     abs1, abs2;
   logic [WIDTH:0]       mul_sum, div_sh, div_diff;
   logic                 div_nb;
   logic [2*WIDTH-1:0]   mul_next, div_next, prod;
   logic [WIDTH-1:0]     quo, rem;

   assign s1   = signed_i & data1_i[WIDTH-1];
   assign s2   = signed_i & data2_i[WIDTH-1];
   assign abs1 = s1 ? -data1_i : data1_i;
   assign abs2 = s2 ? -data2_i : data2_i;

   assign div_zero = op_i[1] && (data2_i == '0);
   assign div_ovf  = signed_i && op_i[1] && (data1_i == MinInt) && (data2_i == '1);

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
   assign mul_next = {(acc_q[0] ? mul_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]}), acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
   assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff = div_sh - {1'b0, opb_q};
   assign div_nb   = ~div_diff[WIDTH];
   assign div_next = {(div_nb ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_nb};

   assign prod = neg_q ? -acc_q : acc_q;
   assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (start_i && !kill_i) begin
               op_d  = op_i;
               neg_d = (op_i == 2'b11) ? s1 : (s1 ^ s2);
               cnt_d = CNT_W'(WIDTH);
               acc_d = {{WIDTH{1'b0}}, (op_i[1] ? abs1 : abs2)};
               opb_d = op_i[1] ? abs2 : abs1;
               if (div_zero) begin
                  data_d  = op_i[0] ? data1_i : '1;
                  state_d = StDone;
               end else if (div_ovf) begin
                  data_d  = op_i[0] ? '0 : MinInt;
                  state_d = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            acc_d = op_q[1] ? div_next : mul_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StFix;
         end
         StFix: begin
            unique case (op_q)
               2'b00:   data_d = prod[WIDTH-1:0];
               2'b01:   data_d = prod[2*WIDTH-1:WIDTH];
               2'b10:   data_d = quo;
               default: data_d = rem;
            endcase
            state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
      // Flush wins over everything, including the FIX write-back.
      if (kill_i && (state_q != StIdle)) begin
         state_d = StIdle;
         data_d  = data_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         op_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         data_q  <= data_d;
      end
   end

   assign busy_o  = (state_q != StIdle);
   assign valid_o = (state_q == StDone);
   assign data_o  = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit at WIDTH=32, plus hand-written
// sequences for reset, flush and ignored-start corner cases.
module tb_muldiv_unit;

   localparam int unsigned W = 32;
   localparam int LatN = W + 2;
   localparam int LatE = 1;

   logic          clk, rst_n, start, kill, sgn;
   logic [1:0]    op;
   logic [W-1:0]  d1, d2;
   logic          busy, valid;
   logic [W-1:0]  dout;

   int n_vec  = 0;
   int n_fail = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .start_i  (start),
      .kill_i   (kill),
      .op_i     (op),
      .signed_i (sgn),
      .data1_i  (d1),
      .data2_i  (d2),
      .busy_o   (busy),
      .valid_o  (valid),
      .data_o   (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t vecs[24];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives a request for one edge (E0); returns at the first falling edge after E0.
   task automatic start_op(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b);
      @(negedge clk);
      op = o; sgn = s; d1 = a; d2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; d1 = ~a; d2 = ~b; op = ~o;
   endtask

   // n counts falling edges after E0; n=k+1 follows edge E0+k.
   task automatic wait_valid(input int start_n, output int n);
      n = start_n;
      while (!valid && n < 80) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int n;
      start_op(v.op, v.sgn, v.a, v.b);
      check({name, " busy"}, {31'b0, busy}, 32'd1);
      wait_valid(1, n);
      check({name, " latency"}, n, v.lat);
      check({name, " data"}, dout, v.exp);
      @(negedge clk);
      check({name, " pulse"}, {31'b0, valid}, 32'd0);
   endtask

   initial begin
      int n, pulses;
      vecs[0]  = '{2'b00, 1'b0, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, LatN};
      vecs[1]  = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, LatN};
      vecs[2]  = '{2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, LatN};
      vecs[3]  = '{2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, LatN};
      vecs[4]  = '{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LatN};
      vecs[5]  = '{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LatN};
      vecs[6]  = '{2'b10, 1'b0, 32'd100,       32'd7,         32'd14,        LatN};
      vecs[7]  = '{2'b11, 1'b0, 32'd100,       32'd7,         32'd2,         LatN};
      vecs[8]  = '{2'b10, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, LatE};
      vecs[9]  = '{2'b11, 1'b0, 32'd5,         32'd0,         32'd5,         LatE};
      vecs[10] = '{2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LatE};
      vecs[11] = '{2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LatE};
      vecs[12] = '{2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LatN};
      vecs[13] = '{2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LatN};
      vecs[14] = '{2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LatN};
      vecs[15] = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LatN};
      vecs[16] = '{2'b10, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LatN};
      vecs[17] = '{2'b11, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         LatN};
      vecs[18] = '{2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LatN};
      vecs[19] = '{2'b10, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         LatN};
      vecs[20] = '{2'b11, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, LatN};
      vecs[21] = '{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LatE};
      vecs[22] = '{2'b00, 1'b0, 32'd12345,     32'd1000,      32'd12345000,  LatN};
      vecs[23] = '{2'b10, 1'b0, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, LatN};

      rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; sgn = 1'b0; d1 = '0; d2 = '0;
      repeat (3) @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset valid", {31'b0, valid}, 32'd0);
      check("reset data", dout, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Start pulse mid-CALC and during DONE must be ignored.
      start_op(2'b00, 1'b0, 32'd7, 32'd6);
      repeat (4) @(negedge clk);
      op = 2'b10; d1 = 32'd100; d2 = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(6, n);
      check("ignored start latency", n, LatN);
      check("ignored start data", dout, 32'd42);
      op = 2'b10; sgn = 1'b0; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start in DONE busy", {31'b0, busy}, 32'd0);

      // Kill together with start in IDLE drops the start.
      @(negedge clk);
      op = 2'b00; d1 = 32'd3; d2 = 32'd3; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("kill+start idle busy", {31'b0, busy}, 32'd0);

      // Flush at E0+10.
      start_op(2'b00, 1'b0, 32'd3, 32'd3);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill busy", {31'b0, busy}, 32'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) pulses++;
      end
      check("kill no valid", pulses, 0);
      check("kill data held", dout, 32'd42);

      // Asynchronous reset mid-CALC.
      start_op(2'b00, 1'b0, 32'd7, 32'd6);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async reset busy", {31'b0, busy}, 32'd0);
      check("async reset data", dout, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) pulses++;
      end
      check("reset no valid", pulses, 0);
      check("reset data zero", dout, 32'd0);
      check("reset idle", {31'b0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
